// File: rtl/rc4_decrypt_message_pkg.sv
// Shared types and helpers for the RC4 decode stage.
package rc4_pkg;

    // One byte walks RD_SI .. WR_DEC (9 states); DONE/FAIL hold the result.
    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        RD_SI  = 4'd1,
        WT_SI  = 4'd2,
        RD_SJ  = 4'd3,
        WT_SJ  = 4'd4,
        WR_SI  = 4'd5,
        WR_SJ  = 4'd6,
        RD_F   = 4'd7,
        WT_F   = 4'd8,
        WR_DEC = 4'd9,
        DONE   = 4'd10,
        FAIL   = 4'd11
    } decode_state_t;

    localparam logic [7:0] CHAR_LO = 8'h61;
    localparam logic [7:0] CHAR_HI = 8'h7A;
    localparam logic [7:0] CHAR_SP = 8'h20;

    // Plaintext is accepted only as lowercase letters or space.
    function automatic logic is_valid_char(input logic [7:0] c);
        return ((c >= CHAR_LO) && (c <= CHAR_HI)) || (c == CHAR_SP);
    endfunction

endpackage

// File: rtl/rc4_decrypt_message_if.sv
// Bundle of the controller handshake and the three memory ports seen by the
// decode stage. master = decode block, slave = memories/controller side.
interface rc4_decrypt_message_if #(
    parameter int MSG_AW = 5
);
    logic              start;
    logic              finish;
    logic              failed;
    logic [7:0]        s_address;
    logic [7:0]        s_data;
    logic              s_wren;
    logic [7:0]        s_q;
    logic [MSG_AW-1:0] enc_address;
    logic [7:0]        enc_q;
    logic [MSG_AW-1:0] dec_address;
    logic [7:0]        dec_data;
    logic              dec_wren;

    modport master (
        input  start, s_q, enc_q,
        output finish, failed, s_address, s_data, s_wren,
               enc_address, dec_address, dec_data, dec_wren
    );

    modport slave (
        output start, s_q, enc_q,
        input  finish, failed, s_address, s_data, s_wren,
               enc_address, dec_address, dec_data, dec_wren
    );
endinterface

// File: rtl/rc4_decrypt_message.sv
// RC4 PRGA decode stage: walks the shuffled S memory, XORs the keystream with
// the encrypted ROM, writes plaintext to the decrypted RAM and reports
// finish/failed with a 4-phase handshake. Every output is a register loaded
// one cycle ahead, so the value seen in a state is set on entry to it.
module rc4_decrypt_message
    import rc4_pkg::*;
#(
    parameter int MSG_LEN     = 32,
    parameter int MSG_AW      = 5,
    parameter int EARLY_ABORT = 1
) (
    input logic                 clk,
    input logic                 reset_n,
    rc4_decrypt_message_if.master bus
);

    localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);
    localparam logic [MSG_AW-1:0] K_ONE  = MSG_AW'(1);

    decode_state_t     state_q, state_d;
    logic [7:0]        i_q, i_d;
    logic [7:0]        j_q, j_d;
    logic [MSG_AW-1:0] k_q, k_d;
    logic [7:0]        si_q, si_d;
    logic [7:0]        sj_q, sj_d;
    logic [7:0]        enc_byte_q, enc_byte_d;
    logic              bad_q, bad_d;

    logic [7:0]        s_address_q, s_address_d;
    logic [7:0]        s_data_q, s_data_d;
    logic              s_wren_q, s_wren_d;
    logic [MSG_AW-1:0] enc_address_q, enc_address_d;
    logic [MSG_AW-1:0] dec_address_q, dec_address_d;
    logic [7:0]        dec_data_q, dec_data_d;
    logic              dec_wren_q, dec_wren_d;
    logic              finish_q, finish_d;
    logic              failed_q, failed_d;

    logic              byte_ok;

    // The byte judged in WR_DEC is the one just presented on dec_data.
    assign byte_ok = is_valid_char(dec_data_q);

    // Next-state, datapath and next-output logic for the decode FSM.
    always_comb begin
        // NOTE: every target gets a default first so no path leaves one unassigned (no latches).
        state_d       = state_q;
        i_d           = i_q;
        j_d           = j_q;
        k_d           = k_q;
        si_d          = si_q;
        sj_d          = sj_q;
        enc_byte_d    = enc_byte_q;
        bad_d         = bad_q;
        s_address_d   = s_address_q;
        s_data_d      = s_data_q;
        s_wren_d      = 1'b0;
        enc_address_d = enc_address_q;
        dec_address_d = dec_address_q;
        dec_data_d    = dec_data_q;
        dec_wren_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    i_d           = 8'd1;
                    j_d           = 8'd0;
                    k_d           = '0;
                    bad_d         = 1'b0;
                    s_address_d   = 8'd1;
                    enc_address_d = '0;
                    state_d       = RD_SI;
                end
            end
            RD_SI: state_d = WT_SI;
            WT_SI: begin
                si_d        = bus.s_q;
                enc_byte_d  = bus.enc_q;
                s_address_d = j_q + bus.s_q;
                state_d     = RD_SJ;
            end
            RD_SJ: begin
                j_d     = j_q + si_q;
                state_d = WT_SJ;
            end
            WT_SJ: begin
                sj_d        = bus.s_q;
                s_address_d = i_q;
                s_data_d    = bus.s_q;
                s_wren_d    = 1'b1;
                state_d     = WR_SI;
            end
            WR_SI: begin
                s_address_d = j_q;
                s_data_d    = si_q;
                s_wren_d    = 1'b1;
                state_d     = WR_SJ;
            end
            WR_SJ: begin
                s_address_d = si_q + sj_q;
                state_d     = RD_F;
            end
            RD_F: state_d = WT_F;
            WT_F: begin
                dec_address_d = k_q;
                dec_data_d    = bus.s_q ^ enc_byte_q;
                dec_wren_d    = 1'b1;
                state_d       = WR_DEC;
            end
            WR_DEC: begin
                bad_d = bad_q | ~byte_ok;
                if (!byte_ok && (EARLY_ABORT != 0)) begin
                    state_d = FAIL;
                end else if (k_q == K_LAST) begin
                    state_d = (bad_q || !byte_ok) ? FAIL : DONE;
                end else begin
                    i_d           = i_q + 8'd1;
                    k_d           = k_q + K_ONE;
                    s_address_d   = i_q + 8'd1;
                    enc_address_d = k_q + K_ONE;
                    state_d       = RD_SI;
                end
            end
            DONE, FAIL: begin
                if (!bus.start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        finish_d = (state_d == DONE);
        failed_d = (state_d == FAIL);
    end

    // State, datapath and output registers; reset returns everything to zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            i_q           <= '0;
            j_q           <= '0;
            k_q           <= '0;
            si_q          <= '0;
            sj_q          <= '0;
            enc_byte_q    <= '0;
            bad_q         <= 1'b0;
            s_address_q   <= '0;
            s_data_q      <= '0;
            s_wren_q      <= 1'b0;
            enc_address_q <= '0;
            dec_address_q <= '0;
            dec_data_q    <= '0;
            dec_wren_q    <= 1'b0;
            finish_q      <= 1'b0;
            failed_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge values together.
            state_q       <= state_d;
            i_q           <= i_d;
            j_q           <= j_d;
            k_q           <= k_d;
            si_q          <= si_d;
            sj_q          <= sj_d;
            enc_byte_q    <= enc_byte_d;
            bad_q         <= bad_d;
            s_address_q   <= s_address_d;
            s_data_q      <= s_data_d;
            s_wren_q      <= s_wren_d;
            enc_address_q <= enc_address_d;
            dec_address_q <= dec_address_d;
            dec_data_q    <= dec_data_d;
            dec_wren_q    <= dec_wren_d;
            finish_q      <= finish_d;
            failed_q      <= failed_d;
        end
    end

    assign bus.s_address   = s_address_q;
    assign bus.s_data      = s_data_q;
    assign bus.s_wren      = s_wren_q;
    assign bus.enc_address = enc_address_q;
    assign bus.dec_address = dec_address_q;
    assign bus.dec_data    = dec_data_q;
    assign bus.dec_wren    = dec_wren_q;
    assign bus.finish      = finish_q;
    assign bus.failed      = failed_q;

endmodule
